mdr_unit: RTL and testbench

- Memory Data Register stage; drives the BusMuxinMDR input of the datapath bus multiplexer.
- Loads from the shared bus (BusMuxOut) or from memory through a request/acknowledge read, and writes its contents to memory through the same handshake.
- A cycle timeout stops a missing memory acknowledge from hanging the control sequencer.

---
 rtl/mdr_unit.sv | 130 +++++++++++++
 tb/tb_mdr_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_unit.sv
// Memory Data Register stage: loads from the bus or from memory via a req/ack read,
// writes its contents back to memory, and aborts a transaction that is never acknowledged.
module mdr_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MDRin,
    input  logic [ADDR_W-1:0] MAR,
    input  logic              rd_start,
    input  logic              wr_start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] BusMuxinMDR,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRdWait, StWrWait, StDone} state_e;

    state_e            stateQ, stateD;
    logic [DATA_W-1:0] mdrQ, mdrD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic              rdQ, rdD;
    logic              wrQ, wrD;
    logic              busyQ, busyD;
    logic              doneQ, doneD;
    logic              errQ, errD;
    logic [CntW-1:0]   cntQ, cntD;

    always_ff @(posedge clk) begin
        if (!clr) begin
            stateQ <= StIdle;
            mdrQ   <= '0;
            addrQ  <= '0;
            rdQ    <= 1'b0;
            wrQ    <= 1'b0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
            errQ   <= 1'b0;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            mdrQ   <= mdrD;
            addrQ  <= addrD;
            rdQ    <= rdD;
            wrQ    <= wrD;
            busyQ  <= busyD;
            doneQ  <= doneD;
            errQ   <= errD;
            cntQ   <= cntD;
        end
    end

    always_comb begin
        stateD = stateQ;
        mdrD   = mdrQ;
        addrD  = addrQ;
        rdD    = rdQ;
        wrD    = wrQ;
        busyD  = busyQ;
        doneD  = 1'b0;
        errD   = errQ;
        cntD   = cntQ;
        case (stateQ)
            StIdle: begin
                // Read beats write; any start beats a bus load.
                if (rd_start || wr_start) begin
                    stateD = rd_start ? StRdWait : StWrWait;
                    addrD  = MAR;
                    rdD    = rd_start;
                    wrD    = !rd_start;
                    busyD  = 1'b1;
                    errD   = 1'b0;
                    cntD   = '0;
                end else if (MDRin) begin
                    mdrD = BusMuxOut;
                end
            end
            StRdWait, StWrWait: begin
                // An ack arriving on the timeout edge still completes the transaction.
                if (mem_ack) begin
                    if (stateQ == StRdWait) begin
                        mdrD = mem_rdata;
                    end
                    rdD    = 1'b0;
                    wrD    = 1'b0;
                    doneD  = 1'b1;
                    stateD = StDone;
                end else if (cntQ == CntLast) begin
                    rdD    = 1'b0;
                    wrD    = 1'b0;
                    errD   = 1'b1;
                    busyD  = 1'b0;
                    stateD = StIdle;
                end else begin
                    cntD = cntQ + CntW'(1);
                end
            end
            StDone: begin
                busyD  = 1'b0;
                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        mem_addr    = addrQ;
        mem_rd      = rdQ;
        mem_wr      = wrQ;
        mem_wdata   = mdrQ;
        BusMuxinMDR = mdrQ;
        busy        = busyQ;
        done        = doneQ;
        timeout_err = errQ;
    end

endmodule

// File: tb/tb_mdr_unit.sv
// Self-checking bench for mdr_unit: a table of read/write transactions checked through a
// scoreboard queue, plus hand-written reset, timeout, priority and mid-transaction-reset cases.
module tb_mdr_unit;

    logic        clk;
    logic        clr;
    logic [31:0] BusMuxOut;
    logic        MDRin;
    logic [8:0]  MAR;
    logic        rd_start;
    logic        wr_start;
    logic [8:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] BusMuxinMDR;
    logic        busy;
    logic        done;
    logic        timeout_err;

    mdr_unit #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(15)) dut (
        .clk        (clk),
        .clr        (clr),
        .BusMuxOut  (BusMuxOut),
        .MDRin      (MDRin),
        .MAR        (MAR),
        .rd_start   (rd_start),
        .wr_start   (wr_start),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .BusMuxinMDR(BusMuxinMDR),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        isWrite;
        logic [8:0]  mar;
        int          ackDelay;
        logic [31:0] rdata;
        logic [31:0] preload;
    } txn_t;

    typedef struct {
        logic [31:0] mdr;
        logic [8:0]  addr;
        int          strobes;
    } exp_t;

    txn_t tbl[6];
    exp_t sbQ[$];
    int   nChecks = 0;
    int   nFail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic loadMdr(input logic [31:0] v);
        BusMuxOut = v;
        MDRin     = 1'b1;
        step();
        MDRin     = 1'b0;
    endtask

    task automatic runTxn(input txn_t t);
        exp_t e;
        int   cyc;
        int   strobes;
        logic strobe;
        loadMdr(t.preload);
        chk("txn_preload", BusMuxinMDR, t.preload);
        MAR      = t.mar;
        rd_start = !t.isWrite;
        wr_start = t.isWrite;
        e.mdr     = t.isWrite ? t.preload : t.rdata;
        e.addr    = t.mar;
        e.strobes = t.ackDelay;
        sbQ.push_back(e);
        step();
        rd_start = 1'b0;
        wr_start = 1'b0;
        MAR      = ~t.mar;
        chk("txn_busy", 32'(busy), 32'd1);
        chk("txn_wdata", mem_wdata, t.preload);
        chk("txn_other_strobe", 32'(t.isWrite ? mem_rd : mem_wr), 32'd0);
        strobes = 0;
        cyc     = 0;
        while (!done && cyc < 40) begin
            strobe = t.isWrite ? mem_wr : mem_rd;
            if (strobe) strobes++;
            mem_ack   = (cyc == t.ackDelay - 1);
            mem_rdata = t.rdata;
            step();
            cyc++;
        end
        mem_ack = 1'b0;
        chk("txn_done_seen", 32'(done), 32'd1);
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            chk("txn_mdr", BusMuxinMDR, e.mdr);
            chk("txn_addr", 32'(mem_addr), 32'(e.addr));
            chk("txn_strobe_cycles", 32'(strobes), 32'(e.strobes));
            chk("txn_busy_in_done", 32'(busy), 32'd1);
            chk("txn_strobe_low", 32'(mem_rd | mem_wr), 32'd0);
        end
        step();
        chk("txn_done_pulse", 32'(done), 32'd0);
        chk("txn_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int   cyc;
        int   strobes;
        logic sawDone;

        tbl[0] = '{1'b0, 9'h05A, 2, 32'h12345678, 32'hDEADBEEF};
        tbl[1] = '{1'b1, 9'h1FF, 1, 32'hA5A5A5A5, 32'h0000CAFE};
        tbl[2] = '{1'b0, 9'h000, 1, 32'hFFFFFFFF, 32'h11111111};
        tbl[3] = '{1'b1, 9'h0AA, 5, 32'h00000000, 32'h80000001};
        tbl[4] = '{1'b0, 9'h155, 15, 32'h0BADF00D, 32'h00000002};
        tbl[5] = '{1'b1, 9'h100, 14, 32'h5555AAAA, 32'hC0FFEE00};

        clr = 1'b0; BusMuxOut = '0; MDRin = 1'b0; MAR = '0;
        rd_start = 1'b0; wr_start = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        step();
        step();
        chk("rst_mdr", BusMuxinMDR, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_strobes", 32'({mem_rd, mem_wr}), 32'd0);
        chk("rst_flags", 32'({busy, done, timeout_err}), 32'd0);
        clr = 1'b1;

        // Bus load, then a stray ack in idle must not touch the MDR.
        loadMdr(32'hDEADBEEF);
        chk("load_mdr", BusMuxinMDR, 32'hDEADBEEF);
        chk("load_quiet", 32'({busy, mem_rd, mem_wr, done}), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_ignored", BusMuxinMDR, 32'hDEADBEEF);
        chk("idle_ack_no_done", 32'({busy, done}), 32'd0);

        for (int i = 0; i < 6; i++) runTxn(tbl[i]);

        // Read that is never acknowledged.
        loadMdr(32'h13579BDF);
        MAR = 9'h033; rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        strobes = 0; cyc = 0; sawDone = 1'b0;
        while (mem_rd && cyc < 40) begin
            strobes++;
            if (done) sawDone = 1'b1;
            step();
            cyc++;
        end
        chk("to_strobe_cycles", 32'(strobes), 32'd15);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_no_done", 32'(sawDone | done), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_mdr", BusMuxinMDR, 32'h13579BDF);
        step();
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        MAR = 9'h044; wr_start = 1'b1;
        step();
        wr_start = 1'b0;
        chk("to_err_cleared", 32'(timeout_err), 32'd0);
        chk("to_wr_strobe", 32'(mem_wr), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("to_wr_done", 32'(done), 32'd1);
        step();

        // All requests at once: read wins, bus load and write are dropped.
        loadMdr(32'h24682468);
        BusMuxOut = 32'hFFFFFFFF; MDRin = 1'b1; rd_start = 1'b1; wr_start = 1'b1; MAR = 9'h0F0;
        step();
        rd_start = 1'b0; wr_start = 1'b0; MDRin = 1'b0;
        chk("pri_rd", 32'(mem_rd), 32'd1);
        chk("pri_no_wr", 32'(mem_wr), 32'd0);
        chk("pri_no_load", BusMuxinMDR, 32'h24682468);
        wr_start = 1'b1; MDRin = 1'b1; MAR = 9'h00F;
        step();
        wr_start = 1'b0; MDRin = 1'b0;
        chk("busy_wr_ignored", 32'(mem_wr), 32'd0);
        chk("busy_addr_stable", 32'(mem_addr), 32'h0F0);
        chk("busy_no_load", BusMuxinMDR, 32'h24682468);
        mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        step();
        mem_ack = 1'b0;
        chk("pri_done", 32'(done), 32'd1);
        chk("pri_mdr", BusMuxinMDR, 32'h55AA55AA);
        rd_start = 1'b1; MDRin = 1'b1;
        step();
        rd_start = 1'b0; MDRin = 1'b0;
        chk("done_start_ignored", 32'({busy, mem_rd, done}), 32'd0);
        chk("done_load_ignored", BusMuxinMDR, 32'h55AA55AA);
        chk("idle_addr_kept", 32'(mem_addr), 32'h0F0);

        // Reset mid-read with a simultaneous ack.
        MAR = 9'h1AB; rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        clr = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
        step();
        clr = 1'b1; mem_ack = 1'b0;
        chk("midrst_mdr", BusMuxinMDR, 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_outs", 32'({mem_rd, mem_wr, busy, done, timeout_err}), 32'd0);
        step();
        chk("midrst_stays_idle", 32'({mem_rd, busy, done}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
